pio_in_edge_irq: RTL and testbench

Parametrised Avalon-MM input PIO: the next generation of the byte-wide edge-capture input port. It adds:
- configurable width and synchroniser depth
- selectable edge mode
- per-bit interrupt mask and IRQ output
- write-1-to-clear capture register

It sits on the HPS lightweight bridge as a status/flag port for FIFO and handshake signals from fabric logic.

---
 rtl/pio_in_edge_irq_if.sv | 25 ++
 rtl/pio_in_edge_irq.sv | 149 ++++++++++++++
 tb/tb_pio_in_edge_irq.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bus bundle for the edge-capture input PIO.
// The master modport belongs to the bridge side; the slave modport belongs to the PIO.
interface pio_in_edge_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pio_in_edge_irq.sv
// Edge-capturing input PIO with per-bit IRQ mask, selectable edge mode and W1C capture flags.
// Optional per-bit debounce filter is enabled by defining PIO_DEBOUNCE_EN.
module pio_in_edge_irq #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  pio_in_edge_irq_if.slave bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  typedef enum logic [1:0] {
    ModeAny  = 2'd0,
    ModeRise = 2'd1,
    ModeFall = 2'd2,
    ModeOff  = 2'd3
  } edge_mode_e;

  if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_param_check
    $error("pio_in_edge_irq: parameter out of range");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] filt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];
  logic [WIDTH-1:0] filt_q, filt_d;

  // A bit must disagree with the filtered value for DEBOUNCE_CYCLES cycles before it is taken.
  always_comb begin
    filt_d = filt_q;
    for (int b = 0; b < int'(WIDTH); b++) begin
      cnt_d[b] = '0;
      if (sync_last[b] != filt_q[b]) begin
        if (cnt_q[b] == CntLast) filt_d[b] = sync_last[b];
        else                     cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= '0;
      for (int b = 0; b < int'(WIDTH); b++) cnt_q[b] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int b = 0; b < int'(WIDTH); b++) cnt_q[b] <= cnt_d[b];
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_last;
`endif

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  edge_mode_e       mode_q, mode_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic             irq_q, irq_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] detect;
  logic [WIDTH-1:0] clear;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^bus.writedata;
  assign wr_en        = bus.chipselect & ~bus.write_n;

  always_comb begin
    detect     = '0;
    clear      = '0;
    mask_d     = mask_q;
    mode_d     = mode_q;
    readdata_d = '0;

    unique case (mode_q)
      ModeAny:  detect = filt ^ prev_q;
      ModeRise: detect = filt & ~prev_q;
      ModeFall: detect = ~filt & prev_q;
      ModeOff:  detect = '0;
      default:  detect = '0;
    endcase

    if (wr_en) begin
      unique case (bus.address)
        2'd1:    mask_d = bus.writedata[WIDTH-1:0];
        2'd2:    mode_d = edge_mode_e'(bus.writedata[1:0]);
        2'd3:    clear  = bus.writedata[WIDTH-1:0];
        default: ;
      endcase
    end

    // A new detection in the same cycle as its clear keeps the flag set.
    cap_d = (cap_q & ~clear) | detect;
    irq_d = |(cap_q & mask_q);

    unique case (bus.address)
      2'd0:    readdata_d = 32'(filt);
      2'd1:    readdata_d = 32'(mask_q);
      2'd2:    readdata_d = 32'(mode_q);
      2'd3:    readdata_d = 32'(cap_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      mask_q     <= '0;
      mode_q     <= ModeAny;
      cap_q      <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      prev_q     <= filt;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      cap_q      <= cap_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Self-checking bench for pio_in_edge_irq: directed steps plus random traffic against a
// cycle-level reference model built from sample history and per-bit stable-run counts.
module tb_pio_in_edge_irq;
  localparam int unsigned W    = 8;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DC   = 16;
`ifdef PIO_DEBOUNCE_EN
  localparam int unsigned LAT = SYNC + 1 + DC;
`else
  localparam int unsigned LAT = SYNC + 1;
`endif

  logic         clk     = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] in_port = '0;
  logic         irq;

  pio_in_edge_irq_if bus ();

  pio_in_edge_irq #(
    .WIDTH          (W),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .in_port(in_port),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_f, m_prev, m_mask, m_cap;
  logic [1:0]   m_mode;
  logic         m_irq;
  logic [31:0]  m_rd;
  int           run[W];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    m_f = '0; m_prev = '0; m_mask = '0; m_cap = '0; m_mode = '0; m_irq = 1'b0; m_rd = '0;
    for (int b = 0; b < int'(W); b++) run[b] = 0;
  endfunction

  function automatic void model_edge();
    logic [W-1:0] det, clr, f_n;
    logic         wr;
`ifdef PIO_DEBOUNCE_EN
    logic [W-1:0] s_cur;
    s_cur = (hist.size() >= int'(SYNC)) ? hist[SYNC-1] : '0;
`endif
    wr = bus.chipselect && !bus.write_n;
    case (m_mode)
      2'd0:    det = m_f ^ m_prev;
      2'd1:    det = m_f & ~m_prev;
      2'd2:    det = ~m_f & m_prev;
      default: det = '0;
    endcase
    case (bus.address)
      2'd0:    m_rd = 32'(m_f);
      2'd1:    m_rd = 32'(m_mask);
      2'd2:    m_rd = 32'(m_mode);
      default: m_rd = 32'(m_cap);
    endcase
    clr = (wr && bus.address == 2'd3) ? bus.writedata[W-1:0] : '0;
    hist.push_front(in_port);
    if (hist.size() > int'(SYNC)) void'(hist.pop_back());
`ifdef PIO_DEBOUNCE_EN
    f_n = m_f;
    for (int b = 0; b < int'(W); b++) begin
      if (s_cur[b] != m_f[b]) begin
        run[b]++;
        if (run[b] == int'(DC)) begin
          f_n[b] = s_cur[b];
          run[b] = 0;
        end
      end else begin
        run[b] = 0;
      end
    end
`else
    f_n = (hist.size() >= int'(SYNC)) ? hist[SYNC-1] : '0;
`endif
    m_irq  = |(m_cap & m_mask);
    m_cap  = (m_cap & ~clr) | det;
    if (wr && bus.address == 2'd1) m_mask = bus.writedata[W-1:0];
    if (wr && bus.address == 2'd2) m_mode = bus.writedata[1:0];
    m_prev = m_f;
    m_f    = f_n;
  endfunction

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".rd"}, bus.readdata, m_rd);
    chk({tag, ".irq"}, {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = '0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input string tag);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    step(tag);
    bus_idle();
  endtask

  task automatic rd(input logic [1:0] a, input string tag, output logic [31:0] v);
    bus.address = a;
    step(tag);
    v = bus.readdata;
    bus.address = 2'd0;
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) step(tag);
  endtask

  initial begin
    logic [31:0] v;
    bus_idle();
    model_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.rd", bus.readdata, 32'h0);
    chk("reset.irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), "reset.reg", v);
      chk("reset.regval", v, 32'h0);
    end

    // Any-edge capture latency and DATA value, mask still 0.
    in_port = 8'h81;
    idle(int'(LAT) - 1, "t1.wait");
    rd(2'd3, "t1.cap_early", v);
    chk("t1.cap_not_yet", v, 32'h0);
    rd(2'd3, "t1.cap", v);
    chk("t1.cap_set", v, 32'h81);
    rd(2'd0, "t1.data", v);
    chk("t1.data", v, 32'h81);
    chk("t1.irq_masked", {31'b0, irq}, 32'h0);

    // Mask enables irq; W1C clears only the written bits.
    wr(2'd1, 32'h01, "t2.mask");
    step("t2.irq_rise");
    chk("t2.irq_on", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h01, "t2.clr");
    rd(2'd3, "t2.cap", v);
    chk("t2.cap_after_clr", v, 32'h80);
    chk("t2.irq_off", {31'b0, irq}, 32'h0);
    wr(2'd3, 32'h00, "t2.clr0");
    rd(2'd3, "t2.cap0", v);
    chk("t2.cap_w0", v, 32'h80);

    // Rising-only then falling-only on bit 2.
    wr(2'd3, 32'hff, "t3.clr");
    wr(2'd2, 32'h1, "t3.rise_mode");
    in_port = 8'h85;
    idle(int'(LAT) + 2, "t3.hi");
    rd(2'd3, "t3.cap_rise", v);
    chk("t3.rise_captured", v, 32'h04);
    wr(2'd3, 32'h04, "t3.clr2");
    in_port = 8'h81;
    idle(int'(LAT) + 2, "t3.lo");
    rd(2'd3, "t3.cap_fall", v);
    chk("t3.fall_ignored", v, 32'h0);
    wr(2'd2, 32'h2, "t3.fall_mode");
    in_port = 8'h85;
    idle(int'(LAT) + 2, "t3.hi2");
    rd(2'd3, "t3.cap_rise2", v);
    chk("t3.rise_ignored", v, 32'h0);
    in_port = 8'h81;
    idle(int'(LAT) + 2, "t3.lo2");
    rd(2'd3, "t3.cap_fall2", v);
    chk("t3.fall_captured", v, 32'h04);

    // Clear lands on the same edge as a new detection of bit 2: set wins.
    wr(2'd3, 32'hff, "t4.clr");
    wr(2'd2, 32'h0, "t4.any_mode");
    in_port = 8'h85;
    idle(int'(LAT) - 1, "t4.wait");
    wr(2'd3, 32'h04, "t4.clr_same");
    rd(2'd3, "t4.cap", v);
    chk("t4.set_wins", v, 32'h04);

    // Disabled mode leaves existing flags and captures nothing new.
    wr(2'd2, 32'h3, "t4.off_mode");
    in_port = 8'h7a;
    idle(int'(LAT) + 2, "t4.off_wait");
    rd(2'd3, "t4.cap_off", v);
    chk("t4.off_holds", v, 32'h04);

`ifdef PIO_DEBOUNCE_EN
    // Short glitch filtered, long pulse accepted.
    wr(2'd2, 32'h0, "t6.mode");
    in_port = 8'h00;
    idle(int'(LAT) + 4, "t6.settle");
    wr(2'd3, 32'hff, "t6.clr");
    in_port = 8'h01;
    idle(10, "t6.glitch");
    in_port = 8'h00;
    idle(int'(LAT) + 4, "t6.after_glitch");
    rd(2'd0, "t6.data_g", v);
    chk("t6.glitch_data", v, 32'h0);
    rd(2'd3, "t6.cap_g", v);
    chk("t6.glitch_cap", v, 32'h0);
    in_port = 8'h01;
    idle(int'(LAT) + 4, "t6.long");
    rd(2'd0, "t6.data_l", v);
    chk("t6.long_data", v, 32'h1);
    rd(2'd3, "t6.cap_l", v);
    chk("t6.long_cap", v, 32'h1);
`endif

    // Random traffic, every cycle checked against the model.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          in_port = W'($urandom);
          idle(int'($urandom_range(1, DC + 8)), "rnd.in");
        end
        1: wr(2'($urandom_range(1, 3)), $urandom, "rnd.wr");
        default: rd(2'($urandom_range(0, 3)), "rnd.rd", v);
      endcase
    end

    // Async reset mid-operation with all flags and mask set.
    wr(2'd1, 32'hff, "t5.mask");
    wr(2'd2, 32'h0, "t5.mode");
    idle(int'(LAT) + 2, "t5.settle");
    wr(2'd3, 32'hff, "t5.clr");
    in_port = ~in_port;
    idle(int'(LAT) + 2, "t5.toggle");
    rd(2'd3, "t5.cap", v);
    chk("t5.cap_full", v, 32'hff);
    chk("t5.irq_high", {31'b0, irq}, 32'h1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t5.rd_async", bus.readdata, 32'h0);
    chk("t5.irq_async", {31'b0, irq}, 32'h0);
    model_reset();
    in_port = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), "t5.reg", v);
      chk("t5.regval", v, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
